// File: rtl/mult_unit_if.sv
// mult_unit_if -- Execute-stage bundle for the HI/LO multiply unit.
//   master : the pipeline side. It drives the request (multE, signedE, srcaE, srcbE)
//            and the mthi/mtlo writes (hiwe, lowe, wd).
//   slave  : the multiply unit. It returns the architectural hi/lo registers,
//            prodv (hi/lo hold a complete product) and busy (iteration in flight).
interface mult_unit_if;
    logic        multE;
    logic        signedE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        hiwe;
    logic        lowe;
    logic [31:0] wd;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        prodv;
    logic        busy;

    modport master (
        output multE, signedE, srcaE, srcbE, hiwe, lowe, wd,
        input  hi, lo, prodv, busy
    );

    modport slave (
        input  multE, signedE, srcaE, srcbE, hiwe, lowe, wd,
        output hi, lo, prodv, busy
    );
endinterface

// File: rtl/mult_unit.sv
// mult_unit -- iterative 32x32 -> 64 multiplier that owns the HI/LO registers.
//   clk   : pipeline clock. All state changes on the rising edge.
//   reset : asynchronous, active-low. Clears all state and discards any in-flight product.
//   bus   : mult_unit_if.slave.
//           - request: multE, signedE, srcaE, srcbE.
//           - mthi/mtlo writes: hiwe, lowe, wd.
//           - results: hi, lo, prodv, busy.
// A start in IDLE latches the operand magnitudes and the result sign.
// BUSY then runs 32 radix-2 shift-add steps. The last step writes the
// sign-corrected product into {hi,lo} and moves to DONE.
// DONE waits for multE to drop, so a held request is never restarted.
module mult_unit (
    input  logic       clk,
    input  logic       reset,
    mult_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, stateNext;
    logic [5:0]  count;
    logic [63:0] multiplicand;   // shifts left one bit per step
    logic [31:0] multiplier;     // shifts right; bit 0 selects the add
    logic [63:0] acc;
    logic        negResult;
    logic [31:0] hiReg, loReg;
    logic        prodvReg;

    logic        start, lastStep, writeOk;
    logic [31:0] magA, magB;
    logic [63:0] accStep, product;

    assign start    = (state == IDLE) && bus.multE;
    assign lastStep = (state == BUSY) && (count == 6'd31);
    // mthi/mtlo are ignored while BUSY, and also when a start takes the same edge.
    assign writeOk  = (state != BUSY) && !start;

    // Magnitudes. 0x80000000 negates to itself, which is still correct when read as unsigned.
    assign magA = (bus.signedE && bus.srcaE[31]) ? -bus.srcaE : bus.srcaE;
    assign magB = (bus.signedE && bus.srcbE[31]) ? -bus.srcbE : bus.srcbE;

    assign accStep = acc + (multiplier[0] ? multiplicand : 64'd0);
    assign product = negResult ? -accStep : accStep;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.multE) stateNext = BUSY;
            BUSY:    if (lastStep)   stateNext = DONE;
            DONE:    if (!bus.multE) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count        <= 6'd0;
            multiplicand <= 64'd0;
            multiplier   <= 32'd0;
            acc          <= 64'd0;
            negResult    <= 1'b0;
            hiReg        <= 32'd0;
            loReg        <= 32'd0;
            prodvReg     <= 1'b1;   // HI/LO=0 after reset counts as a valid product
        end else begin
            if (start) begin
                count        <= 6'd0;
                multiplicand <= {32'd0, magA};
                multiplier   <= magB;
                acc          <= 64'd0;
                negResult    <= bus.signedE & (bus.srcaE[31] ^ bus.srcbE[31]);
                prodvReg     <= 1'b0;
            end else if (state == BUSY) begin
                count        <= count + 6'd1;
                acc          <= accStep;
                multiplicand <= multiplicand << 1;
                multiplier   <= multiplier >> 1;
                if (lastStep) begin
                    {hiReg, loReg} <= product;
                    prodvReg       <= 1'b1;
                end
            end
            if (writeOk) begin
                if (bus.hiwe) hiReg <= bus.wd;
                if (bus.lowe) loReg <= bus.wd;
            end
        end
    end

    assign bus.hi    = hiReg;
    assign bus.lo    = loReg;
    assign bus.prodv = prodvReg;
    assign bus.busy  = (state == BUSY);
endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit -- directed self-checking bench for mult_unit.
// Each vector carries a hand-computed product.
// modelHi/modelLo track what hi/lo must hold between operations.
module tb_mult_unit;
    logic clk = 1'b0;
    logic reset;
    int   nChecks = 0;
    int   nFails  = 0;
    logic [31:0] modelHi, modelLo;

    mult_unit_if mif ();

    mult_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Clocks until prodv rises, with a 100-cycle bound.
    // On the way, confirms that hi/lo keep their previous value mid-BUSY.
    task automatic waitDone(input string tag, output int cnt);
        cnt = 0;
        while (!mif.prodv && cnt < 100) begin
            if (cnt == 16) begin
                check({tag, " hi held in BUSY"}, 64'(mif.hi), 64'(modelHi));
                check({tag, " lo held in BUSY"}, 64'(mif.lo), 64'(modelLo));
            end
            step();
            cnt++;
        end
    endtask

    task automatic runMult(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eHi, input logic [31:0] eLo);
        int cnt;
        mif.multE = 1'b1; mif.signedE = s; mif.srcaE = a; mif.srcbE = b;
        step();
        check({tag, " busy after start"}, 64'(mif.busy), 64'd1);
        check({tag, " prodv after start"}, 64'(mif.prodv), 64'd0);
        waitDone(tag, cnt);
        check({tag, " latency"}, 64'(cnt), 64'd32);
        check({tag, " hi"}, 64'(mif.hi), 64'(eHi));
        check({tag, " lo"}, 64'(mif.lo), 64'(eLo));
        modelHi = eHi; modelLo = eLo;
        mif.multE = 1'b0;
        step();
        check({tag, " idle busy"}, 64'(mif.busy), 64'd0);
    endtask

    initial begin
        int cnt, riseAt, bad;
        reset = 1'b0;
        mif.multE = 1'b0; mif.signedE = 1'b0; mif.srcaE = '0; mif.srcbE = '0;
        mif.hiwe = 1'b0; mif.lowe = 1'b0; mif.wd = '0;
        modelHi = '0; modelLo = '0;
        #12;
        check("reset hi", 64'(mif.hi), 64'd0);
        check("reset lo", 64'(mif.lo), 64'd0);
        check("reset prodv", 64'(mif.prodv), 64'd1);
        check("reset busy", 64'(mif.busy), 64'd0);
        reset = 1'b1;
        step();

        runMult("multu 7x6", 1'b0, 32'd7, 32'd6, 32'h0, 32'h2A);
        runMult("mult -3x5", 1'b1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        runMult("mult min*min", 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
        runMult("mult min*1", 1'b1, 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h80000000);
        runMult("multu max*max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1);
        runMult("mult -1*-1", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1);
        runMult("multu 2^31*4", 1'b0, 32'h80000000, 32'd4, 32'h2, 32'h0);

        // A request held for 50 cycles must compute exactly once.
        mif.multE = 1'b1; mif.signedE = 1'b0; mif.srcaE = 32'd3; mif.srcbE = 32'd4;
        step();
        riseAt = -1; bad = 0;
        for (int i = 1; i < 50; i++) begin
            step();
            if (mif.prodv && riseAt < 0) riseAt = i;
            if (riseAt >= 0 && (!mif.prodv || mif.busy || mif.lo != 32'd12 || mif.hi != 32'd0)) bad++;
        end
        check("held rise cycle", 64'(riseAt), 64'd32);
        check("held stable", 64'(bad), 64'd0);
        modelHi = 32'd0; modelLo = 32'd12;
        mif.multE = 1'b0;
        step();

        // Reset mid-BUSY: in-flight product discarded immediately.
        mif.multE = 1'b1; mif.srcaE = 32'd9; mif.srcbE = 32'd9;
        step();
        mif.multE = 1'b0;
        for (int i = 0; i < 10; i++) step();
        reset = 1'b0;
        #1;
        check("midreset hi", 64'(mif.hi), 64'd0);
        check("midreset lo", 64'(mif.lo), 64'd0);
        check("midreset prodv", 64'(mif.prodv), 64'd1);
        check("midreset busy", 64'(mif.busy), 64'd0);
        modelHi = '0; modelLo = '0;
        #2 reset = 1'b1;
        step();
        runMult("post-reset 2x3", 1'b0, 32'd2, 32'd3, 32'h0, 32'h6);

        // mtlo while BUSY is ignored. In DONE it lands and prodv stays 1.
        mif.multE = 1'b1; mif.srcaE = 32'd5; mif.srcbE = 32'd5;
        step();
        step(); step();
        mif.lowe = 1'b1; mif.wd = 32'h1234;
        step();
        mif.lowe = 1'b0;
        check("mtlo busy ignored", 64'(mif.lo), 64'(modelLo));
        waitDone("mtlo run", cnt);
        check("mtlo run latency", 64'(cnt), 64'd29);
        check("mtlo run lo", 64'(mif.lo), 64'd25);
        mif.lowe = 1'b1;
        step();
        mif.lowe = 1'b0;
        check("mtlo done lo", 64'(mif.lo), 64'h1234);
        check("mtlo done prodv", 64'(mif.prodv), 64'd1);
        check("done no restart", 64'(mif.busy), 64'd0);
        mif.multE = 1'b0;
        step();

        // mthi in IDLE.
        mif.hiwe = 1'b1; mif.wd = 32'hABCD0000;
        step();
        mif.hiwe = 1'b0;
        check("mthi idle hi", 64'(mif.hi), 64'hABCD0000);
        check("mthi idle prodv", 64'(mif.prodv), 64'd1);
        modelHi = 32'hABCD0000; modelLo = 32'h1234;

        // A start and an mtlo on the same edge: the start wins.
        mif.multE = 1'b1; mif.srcaE = 32'd4; mif.srcbE = 32'd4;
        mif.lowe = 1'b1; mif.wd = 32'hDEAD;
        step();
        mif.lowe = 1'b0;
        check("start+wr lo kept", 64'(mif.lo), 64'h1234);
        check("start+wr busy", 64'(mif.busy), 64'd1);
        waitDone("start+wr", cnt);
        check("start+wr latency", 64'(cnt), 64'd32);
        check("start+wr lo", 64'(mif.lo), 64'd16);
        check("start+wr hi", 64'(mif.hi), 64'd0);
        mif.multE = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 SHALL have: clk  input  1  pipeline clock; all state changes on rising edge.
REQ-002 SHALL have: reset  input  1  asynchronous, active-low; clears all state immediately when low.
REQ-003 SHALL have: multE  input  1  level request from Execute stage: a mult/multu is in E.
REQ-004 SHALL have: signedE  input  1  1 = mult (two's complement), 0 = multu; sampled with multE.
REQ-005 SHALL have: srcaE, srcbE  input  32  operands; sampled only on the start edge.
REQ-006 SHALL have: hiwe, lowe  input  1  mthi/mtlo write enables.
REQ-007 SHALL have: wd  input  32  mthi/mtlo write data.
REQ-008 SHALL have: hi, lo  output  32  architectural HI/LO registers.
REQ-009 SHALL have: prodv  output  1  HI/LO hold a complete, valid product; feeds the hazard unit's multiply stall (stall = aluormultE & ~prodv).
REQ-010 SHALL have: busy  output  1  high while an iteration is in progress.

Function
REQ-011 SHALL implement the FSM IDLE -> BUSY -> DONE -> IDLE, plus a 6-bit iteration counter, an operand/partial-product datapath and a sign flag.
REQ-012 IDLE: multE=1 on an edge is a start; latch |srcaE|, |srcbE| (magnitudes only if signedE), latch the result sign (sa^sb if signed, else 0), clear the 64-bit accumulator, set counter=0, prodv->0, go to BUSY.
REQ-013 BUSY: one radix-2 shift-add step per cycle, for exactly 32 cycles (counter 0..31); busy=1 throughout.
REQ-014 On the 32nd BUSY edge, write {hi,lo} = the 64-bit product (negated if the sign flag is set), set prodv->1 and go to DONE; total latency is 32 cycles of prodv=0 after the start edge.
REQ-015 DONE: stay while multE=1, so a held request is never restarted; return to IDLE when multE=0.
REQ-016 A new start is only accepted from IDLE; multE asserted in DONE does not restart.
REQ-017 Back-to-back mults (multE drops for 1 cycle) start from IDLE on the next multE edge; prodv falls on that edge.
REQ-018 hiwe/lowe in IDLE or DONE write wd to hi/lo on the edge and leave prodv=1; writes are ignored while BUSY.
REQ-019 A start and a write on the same edge in IDLE: the start wins, the write is ignored.
REQ-020 hi/lo are unchanged during BUSY and hold their previous value until the final BUSY edge.
REQ-021 Results are bit-exact to the 64-bit product of the 32x32 operands, for both signed and unsigned, including 0x80000000 operands.
REQ-022 busy = (state==BUSY); prodv is registered, never combinational from multE.

Reset
REQ-023 reset low, at any time including mid-BUSY: state=IDLE, counter=0, hi=0, lo=0, busy=0, prodv=1 (HI/LO=0 is treated as valid so mfhi/mflo after reset never stall); any in-flight product is discarded.
REQ-024 After reset deasserts, the first start behaves per REQ-012 with no residual state.

Verification
REQ-025 multu 7 x 6: multE=1, signedE=0 -> prodv low for 32 cycles, then hi=0x00000000, lo=0x0000002A, prodv=1.
REQ-026 mult -3 x 5 (0xFFFFFFFD, 0x00000005) -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; mult 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-027 multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; the same operands with signed -> hi=0, lo=1.
REQ-028 multE held for 50 cycles -> exactly one computation, prodv rises at cycle 32 and stays high, hi/lo stable.
REQ-029 reset pulsed low at BUSY cycle 10 -> immediately hi=lo=0, prodv=1, busy=0; a following start of 2 x 3 yields lo=6 after 32 cycles.
REQ-030 mtlo 0x1234 during BUSY -> ignored, lo=product at completion; mtlo 0x1234 in DONE -> lo=0x1234, prodv stays 1.
